// File: rtl/fetch_stage_pkg.sv
// Shared pipeline definitions: fetch FSM encoding, canonical NOP and
// RISC-V register-field positions used by the fetch stage and hazard logic.
package fetch_stage_pkg;

  typedef enum logic [2:0] {
    BOOT  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    HOLD  = 3'd3,
    DRAIN = 3'd4
  } fetch_state_e;

  // addi x0, x0, 0
  localparam logic [31:0] RV_NOP = 32'h0000_0013;

  localparam int REG_ADDR_W = 5;
  localparam int RS_LSB     = 15;
  localparam int RT_LSB     = 20;

endpackage

// File: rtl/fetch_stage.sv
// Instruction fetch stage: single-outstanding imem requester feeding IF/ID.
// Optional performance counters enabled by defining FETCH_PERF_CNT_EN.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = RV_NOP
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pcWrite,
  input  logic        if_idWrite,
  input  logic        pipelineFlush,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] IF_ID_pc,
  output logic [31:0] IF_ID_instr,
  output logic        IF_ID_valid,
  output logic [4:0]  IF_ID_rs,
  output logic [4:0]  IF_ID_rt
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_stall_cycles,
  output logic [31:0] perf_flush_count
`endif
);

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  fetch_state_e state, state_nxt;
  logic [31:0]  pc;
  logic [31:0]  hold_instr_p0;
  logic [31:0]  deliver_word;
  logic         deliver;
  logic         capture;
  logic         pc_inc;
  logic         unused_tgt_lsbs;

  assign unused_tgt_lsbs = ^branch_target[1:0];
  assign imem_addr       = pc;
  assign deliver_word    = (state == HOLD) ? hold_instr_p0 : imem_rdata;
  assign IF_ID_rs        = IF_ID_instr[RS_LSB +: REG_ADDR_W];
  assign IF_ID_rt        = IF_ID_instr[RT_LSB +: REG_ADDR_W];

  always_ff @(posedge clk) begin
    if (rst) state <= BOOT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    imem_req  = 1'b0;
    deliver   = 1'b0;
    capture   = 1'b0;
    pc_inc    = 1'b0;
    case (state)
      BOOT:  state_nxt = ISSUE;
      ISSUE: begin
        imem_req  = 1'b1;
        state_nxt = branch_taken ? DRAIN : WAIT;
      end
      WAIT: begin
        if (branch_taken) begin
          state_nxt = imem_valid ? ISSUE : DRAIN;
        end else if (imem_valid) begin
          if (if_idWrite) begin
            deliver   = 1'b1;
            pc_inc    = pcWrite;
            state_nxt = ISSUE;
          end else begin
            capture   = 1'b1;
            state_nxt = HOLD;
          end
        end
      end
      HOLD: begin
        if (branch_taken) begin
          state_nxt = ISSUE;
        end else if (if_idWrite) begin
          deliver   = 1'b1;
          pc_inc    = pcWrite;
          state_nxt = ISSUE;
        end
      end
      DRAIN: if (imem_valid) state_nxt = ISSUE;
      default: state_nxt = BOOT;
    endcase
    // never launch a request on a reset edge: the response would be orphaned
    if (rst) imem_req = 1'b0;
  end

  // ---- PC, hold buffer and IF/ID register ----
  always_ff @(posedge clk) begin
    if (rst) begin
      pc            <= {RESET_PC[31:2], 2'b00};
      hold_instr_p0 <= 32'h0;
      IF_ID_pc      <= 32'h0;
      IF_ID_instr   <= NOP_INSTR;
      IF_ID_valid   <= 1'b0;
    end else begin
      if (branch_taken)  pc <= {branch_target[31:2], 2'b00};
      else if (pc_inc)   pc <= pc + 32'd4;

      if (branch_taken)  hold_instr_p0 <= 32'h0;
      else if (capture)  hold_instr_p0 <= imem_rdata;

      if (branch_taken || pipelineFlush || (if_idWrite && !deliver)) begin
        IF_ID_pc    <= 32'h0;
        IF_ID_instr <= NOP_INSTR;
        IF_ID_valid <= 1'b0;
      end else if (deliver) begin
        IF_ID_pc    <= pc;
        IF_ID_instr <= deliver_word;
        IF_ID_valid <= 1'b1;
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  // ---- performance counters ----
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cycles <= 32'h0;
      perf_flush_count  <= 32'h0;
    end else begin
      if (!if_idWrite)                    perf_stall_cycles <= sat_inc(perf_stall_cycles);
      if (branch_taken || pipelineFlush)  perf_flush_count  <= sat_inc(perf_flush_count);
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a transaction-level reference model
// and a latency-programmable instruction memory responder.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst, pcWrite, if_idWrite, pipelineFlush, branch_taken;
  logic [31:0] branch_target;
  logic        imem_req, imem_valid;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] IF_ID_pc, IF_ID_instr;
  logic        IF_ID_valid;
  logic [4:0]  IF_ID_rs, IF_ID_rt;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_stall_cycles, perf_flush_count;
`endif

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk(clk), .rst(rst), .pcWrite(pcWrite), .if_idWrite(if_idWrite),
    .pipelineFlush(pipelineFlush), .branch_taken(branch_taken),
    .branch_target(branch_target), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_rdata(imem_rdata), .IF_ID_pc(IF_ID_pc),
    .IF_ID_instr(IF_ID_instr), .IF_ID_valid(IF_ID_valid),
    .IF_ID_rs(IF_ID_rs), .IF_ID_rt(IF_ID_rt)
`ifdef FETCH_PERF_CNT_EN
    , .perf_stall_cycles(perf_stall_cycles), .perf_flush_count(perf_flush_count)
`endif
  );

  int passed = 0;
  int total  = 0;

  // memory responder
  int          lat = 1;
  int          resp_cnt = 0;
  logic [31:0] resp_addr = 32'h0;

  // reference model: fetch as "request whenever nothing is pending"
  logic [31:0] m_pc = 32'h0, m_if_pc = 32'h0, m_if_instr = 32'h13, m_held_word = 32'h0;
  logic        m_if_vld = 1'b0, m_boot = 1'b1, m_out = 1'b0, m_drop = 1'b0, m_held = 1'b0;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] m_stall = 32'h0, m_flush = 32'h0;
`endif

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return (a << 13) ^ a ^ 32'h0040_0033;
  endfunction

  function automatic logic exp_req();
    return !rst && !m_boot && !m_out && !m_held;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic model_step();
    logic        delivered, issuing;
    logic [31:0] w;
    delivered = 1'b0;
    w = 32'h0;
    if (rst) begin
      m_pc = 32'h0; m_if_pc = 32'h0; m_if_instr = 32'h13; m_if_vld = 1'b0;
      m_boot = 1'b1; m_out = 1'b0; m_drop = 1'b0; m_held = 1'b0;
`ifdef FETCH_PERF_CNT_EN
      m_stall = 32'h0; m_flush = 32'h0;
`endif
    end else begin
      issuing = !m_boot && !m_out && !m_held;
      if (m_out && imem_valid) begin
        m_out = 1'b0;
        if (m_drop || branch_taken) m_drop = 1'b0;
        else if (if_idWrite) begin delivered = 1'b1; w = imem_rdata; end
        else begin m_held = 1'b1; m_held_word = imem_rdata; end
      end else if (m_held && !branch_taken && if_idWrite) begin
        delivered = 1'b1; w = m_held_word; m_held = 1'b0;
      end
      if (branch_taken) begin
        m_held = 1'b0;
        if (m_out) m_drop = 1'b1;
      end
      if (issuing) begin m_out = 1'b1; m_drop = branch_taken; end
      m_boot = 1'b0;
      if (branch_taken || pipelineFlush) begin
        m_if_pc = 32'h0; m_if_instr = 32'h13; m_if_vld = 1'b0;
      end else if (delivered) begin
        m_if_pc = m_pc; m_if_instr = w; m_if_vld = 1'b1;
      end else if (if_idWrite) begin
        m_if_pc = 32'h0; m_if_instr = 32'h13; m_if_vld = 1'b0;
      end
      if (branch_taken)                m_pc = branch_target & 32'hFFFF_FFFC;
      else if (delivered && pcWrite)   m_pc = m_pc + 32'd4;
`ifdef FETCH_PERF_CNT_EN
      if (!if_idWrite)                   m_stall = m_stall + 32'd1;
      if (branch_taken || pipelineFlush) m_flush = m_flush + 32'd1;
`endif
    end
  endtask

  task automatic compare();
    logic [31:0] ei;
    ei = m_if_instr;
    chk("imem_req", 32'(imem_req), 32'(exp_req()));
    if (exp_req()) chk("imem_addr", imem_addr, m_pc);
    chk("IF_ID_pc", IF_ID_pc, m_if_pc);
    chk("IF_ID_instr", IF_ID_instr, ei);
    chk("IF_ID_valid", 32'(IF_ID_valid), 32'(m_if_vld));
    chk("IF_ID_rs", 32'(IF_ID_rs), 32'(ei[19:15]));
    chk("IF_ID_rt", 32'(IF_ID_rt), 32'(ei[24:20]));
`ifdef FETCH_PERF_CNT_EN
    chk("perf_stall_cycles", perf_stall_cycles, m_stall);
    chk("perf_flush_count", perf_flush_count, m_flush);
`endif
  endtask

  task automatic responder();
    if (resp_cnt > 0) begin
      resp_cnt--;
      imem_valid = (resp_cnt == 0);
      imem_rdata = (resp_cnt == 0) ? word_at(resp_addr) : 32'hDEAD_BEEF;
    end else begin
      imem_valid = 1'b0;
      imem_rdata = 32'hDEAD_BEEF;
    end
    if (imem_req) begin
      resp_cnt  = lat;
      resp_addr = imem_addr;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
    responder();
  endtask

  task automatic wait_req(output logic [31:0] a);
    logic found;
    found = 1'b0;
    a = 32'hX;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (imem_req) begin
        found = 1'b1;
        a = imem_addr;
      end
    end
    if (!found) begin
      total++;
      $display("FAIL wait_req timeout: no imem_req within 20 cycles (t=%0t)", $time);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    rst = 1'b1; pcWrite = 1'b1; if_idWrite = 1'b1; pipelineFlush = 1'b0;
    branch_taken = 1'b0; branch_target = 32'h0; imem_valid = 1'b0; imem_rdata = 32'h0;
    tick(); tick();
    chk("reset imem_req", 32'(imem_req), 32'h0);
    chk("reset IF_ID_valid", 32'(IF_ID_valid), 32'h0);
    chk("reset IF_ID_instr", IF_ID_instr, 32'h0000_0013);
    chk("reset IF_ID_pc", IF_ID_pc, 32'h0);
    rst = 1'b0;

    // straight-line fetch, 1-cycle memory
    wait_req(a); chk("seq addr 0", a, 32'h0);
    wait_req(a); chk("seq addr 4", a, 32'h4);
    chk("seq IF_ID_pc 0", IF_ID_pc, 32'h0);
    chk("seq IF_ID_valid", 32'(IF_ID_valid), 32'h1);
    wait_req(a); chk("seq addr 8", a, 32'h8);
    chk("seq IF_ID_pc 4", IF_ID_pc, 32'h4);

    // stall while the response for 0x8 returns
    if_idWrite = 1'b0; pcWrite = 1'b0;
    repeat (3) tick();
    if_idWrite = 1'b1; pcWrite = 1'b1;
    tick();
    chk("hold release IF_ID_valid", 32'(IF_ID_valid), 32'h1);
    chk("hold release IF_ID_pc", IF_ID_pc, 32'h8);
    chk("hold release IF_ID_instr", IF_ID_instr, word_at(32'h8));
    chk("hold next imem_req", 32'(imem_req), 32'h1);
    chk("hold next imem_addr", imem_addr, 32'hC);

    // redirect while waiting on a 3-cycle memory
    lat = 3;
    wait_req(a); chk("pre-branch addr", a, 32'h10);
    tick();
    branch_taken = 1'b1; branch_target = 32'h100;
    tick();
    branch_taken = 1'b0;
    chk("drain IF_ID_valid", 32'(IF_ID_valid), 32'h0);
    chk("drain imem_req", 32'(imem_req), 32'h0);
    wait_req(a); chk("branch target addr", a, 32'h100);

    // redirect coinciding with a response
    lat = 1;
    wait_req(a); chk("post-branch addr", a, 32'h104);
    tick();
    branch_taken = 1'b1; branch_target = 32'h203;
    tick();
    branch_taken = 1'b0;
    chk("same-cycle imem_req", 32'(imem_req), 32'h1);
    chk("same-cycle imem_addr", imem_addr, 32'h200);
    chk("same-cycle IF_ID_valid", 32'(IF_ID_valid), 32'h0);

    // flush overriding a stalled IF/ID
    tick(); tick();
    chk("pre-flush IF_ID_pc", IF_ID_pc, 32'h200);
    chk("pre-flush IF_ID_valid", 32'(IF_ID_valid), 32'h1);
    pipelineFlush = 1'b1; if_idWrite = 1'b0; pcWrite = 1'b0;
    tick();
    pipelineFlush = 1'b0;
    chk("flush IF_ID_instr", IF_ID_instr, 32'h0000_0013);
    chk("flush IF_ID_valid", 32'(IF_ID_valid), 32'h0);
    tick();
    if_idWrite = 1'b1; pcWrite = 1'b1;
    wait_req(a); chk("post-flush addr", a, 32'h208);
    chk("post-flush IF_ID_pc", IF_ID_pc, 32'h204);

    // reset while a request is outstanding
    lat = 3;
    wait_req(a); chk("pre-reset addr", a, 32'h20C);
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid-reset IF_ID_valid", 32'(IF_ID_valid), 32'h0);
    chk("mid-reset imem_req", 32'(imem_req), 32'h0);
    lat = 1;
    wait_req(a); chk("post-reset addr", a, 32'h0);

    // PC wrap from the top of the address space
    branch_taken = 1'b1; branch_target = 32'hFFFF_FFFF;
    tick();
    branch_taken = 1'b0;
    wait_req(a); chk("wrap top addr", a, 32'hFFFF_FFFC);
    wait_req(a); chk("wrap addr 0", a, 32'h0);
    chk("wrap IF_ID_pc", IF_ID_pc, 32'hFFFF_FFFC);

    repeat (4) tick();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
